// File: rtl/bcd_disp_pkg.sv
// Shared seven-segment glyph constants and BCD-to-glyph decode for the score display.
// Glyphs are active-low {a,b,c,d,e,f,g}.
package bcd_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = SEG_0;
            4'd1:    g = SEG_1;
            4'd2:    g = SEG_2;
            4'd3:    g = SEG_3;
            4'd4:    g = SEG_4;
            4'd5:    g = SEG_5;
            4'd6:    g = SEG_6;
            4'd7:    g = SEG_7;
            4'd8:    g = SEG_8;
            4'd9:    g = SEG_9;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the ripple counter: computes the next digit value and the carry/borrow
// passed to the next more significant digit. Purely combinational; the top holds the state.
module bcd_digit
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       carry_in,
    input  logic       borrow_in,
    output logic [3:0] result,
    output logic       carry_out,
    output logic       borrow_out
);

    // Increment wins if both were ever raised; the top never raises both.
    always_comb begin
        result     = digit;
        carry_out  = 1'b0;
        borrow_out = 1'b0;
        if (carry_in) begin
            if (digit >= 4'd9) begin
                result    = 4'd0;
                carry_out = 1'b1;
            end else begin
                result = digit + 4'd1;
            end
        end else if (borrow_in) begin
            if (digit == 4'd0) begin
                result     = 4'd9;
                borrow_out = 1'b1;
            end else begin
                result = digit - 4'd1;
            end
        end else begin
            result = digit;
        end
    end

endmodule

// File: rtl/bcd_score_display.sv
// N-digit BCD up/down score counter with wrap/saturate limits and a registered,
// leading-zero-blanking multiplexed seven-segment scanner.
module bcd_score_display
    import bcd_disp_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 16,
    parameter int SATURATE = 0,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  clear,
    input  logic                  inc,
    input  logic                  dec,
    output logic [4*DIGITS-1:0]   score,
    output logic                  limit,
    output logic [6:0]            segment,
    output logic [DIGITS-1:0]     seg_sel
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] score_r;
    logic                limit_r;
    logic [6:0]          segment_r;
    logic [DIGITS-1:0]   seg_sel_r;
    logic [SCAN_DIV-1:0] prescaler_r;
    logic [IDX_W-1:0]    idx_r;

    logic [DIGITS:0]     carry_s;
    logic [DIGITS:0]     borrow_s;
    logic [4*DIGITS-1:0] sum_s;
    logic [4*DIGITS-1:0] score_next_s;
    logic                limit_next_s;
    logic                edge_s;
    logic [DIGITS-1:0]   blank_s;
    logic [IDX_W-1:0]    idx_next_s;
    logic [6:0]          glyph_s;
    logic                scan_adv_s;

    // Conflicting or cleared strobes never enter the ripple chain.
    assign carry_s[0]  = inc & ~dec & ~clear;
    assign borrow_s[0] = dec & ~inc & ~clear;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit u_digit (
                .digit      (score_r[4*g +: 4]),
                .carry_in   (carry_s[g]),
                .borrow_in  (borrow_s[g]),
                .result     (sum_s[4*g +: 4]),
                .carry_out  (carry_s[g+1]),
                .borrow_out (borrow_s[g+1])
            );
        end
    endgenerate

    assign edge_s = carry_s[DIGITS] | borrow_s[DIGITS];

    // Next score: clear first, then saturation override at the limits.
    always_comb begin
        score_next_s = sum_s;
        limit_next_s = 1'b0;
        if (clear) begin
            score_next_s = '0;
            limit_next_s = 1'b0;
        end else if (edge_s && (SATURATE != 0)) begin
            score_next_s = score_r;
            limit_next_s = 1'b1;
        end else begin
            score_next_s = sum_s;
            limit_next_s = edge_s;
        end
    end

    // Digit k is blank when it and every more significant digit are zero.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank_s    = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (score_r[4*k +: 4] == 4'd0);
            blank_s[k] = (BLANK_LZ != 0) && (k > 0) && zero_above;
        end
    end

    assign scan_adv_s = &prescaler_r;

    // Next scan slot and its glyph, so segment and seg_sel update together.
    always_comb begin
        idx_next_s = '0;
        glyph_s    = SEG_BLANK;
        if (idx_r == IDX_W'(DIGITS - 1)) begin
            idx_next_s = '0;
        end else begin
            idx_next_s = idx_r + IDX_W'(1);
        end
        if (blank_s[idx_next_s]) begin
            glyph_s = SEG_BLANK;
        end else begin
            glyph_s = bcd_to_seg(score_r[{idx_next_s, 2'b00} +: 4]);
        end
    end

    // Score counter and one-cycle limit pulse.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            score_r <= '0;
            limit_r <= 1'b0;
        end else begin
            score_r <= score_next_s;
            limit_r <= limit_next_s;
        end
    end

    // Free-running scan prescaler with registered digit select and glyph.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            prescaler_r <= '0;
            idx_r       <= '0;
            seg_sel_r   <= DIGITS'(1);
            segment_r   <= SEG_0;
        end else begin
            prescaler_r <= prescaler_r + SCAN_DIV'(1);
            if (scan_adv_s) begin
                idx_r     <= idx_next_s;
                seg_sel_r <= DIGITS'(1) << idx_next_s;
                segment_r <= glyph_s;
            end
        end
    end

    assign score   = score_r;
    assign limit   = limit_r;
    assign segment = segment_r;
    assign seg_sel = seg_sel_r;

endmodule

// File: doc/bcd_score_display.md
Name: bcd_score_display

Overview:
- Parametrised N-digit BCD score counter with a built-in multiplexed seven-segment scanner. It replaces the chained single-digit decimal counters and the separate number-to-segment block in the reaction-game top level.
- Increment and decrement strobes come from switch/LED hit logic. Outputs drive the board's shared segment bus and the one-hot digit selects directly.
- Adds the following over the previous design:
  - decrement;
  - synchronous clear;
  - wrap or saturate mode;
  - an overflow/underflow flag;
  - leading-zero blanking;
  - a properly registered scan.

Parameters:
- DIGITS, 4, number of BCD digits and digit-select lines (1..8).
- SCAN_DIV, 16, prescaler width; scan advances once every 2**SCAN_DIV clk cycles.
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits.
- BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 always lit), 0 = show all digits.

Ports:
- clk, input, 1, system clock.
- clr, input, 1, asynchronous active-high reset.
- clear, input, 1, synchronous score clear strobe.
- inc, input, 1, single-cycle increment strobe.
- dec, input, 1, single-cycle decrement strobe.
- score, output, 4*DIGITS, registered BCD value; digit i is at [4i+3:4i].
- limit, output, 1, one-cycle pulse on wrap or saturate event.
- segment, output, 7, active-low {a,b,c,d,e,f,g} of the selected digit.
- seg_sel, output, DIGITS, one-hot active-high digit select.

Behaviour:
- Reset (clr high, asynchronous) sets:
  - score = 0, limit = 0, prescaler = 0;
  - seg_sel = 1 (digit 0);
  - segment = 7'b0000001 (glyph "0").
- Counter priority, evaluated each rising clk edge:
  1. clear: score <= 0, limit <= 0.
  2. inc and dec both high: no change, limit <= 0.
  3. inc alone: add 1 with BCD ripple carry across all digits in one cycle.
  4. dec alone: subtract 1 with BCD ripple borrow.
  5. Otherwise hold.
- Latency: score reflects a strobe on the edge that samples it, so it is visible 1 cycle later.
- Increment at all-9s:
  - SATURATE=0: wraps to 0.
  - SATURATE=1: holds all-9s.
  - In both cases limit pulses for 1 cycle.
- Decrement at 0:
  - SATURATE=0: wraps to all-9s.
  - SATURATE=1: holds 0.
  - In both cases limit pulses for 1 cycle.
- limit is 0 on every other cycle.
- Digit values are always 0..9; no non-BCD code can be produced.
- Prescaler: SCAN_DIV-bit free-running counter. When it equals all-ones, the scan index advances:
  - seg_sel rotates left by one;
  - from bit DIGITS-1 it returns to bit 0.
- segment is registered on the same edge as seg_sel, so the glyph always matches the newly selected digit; no one-cycle mismatch is allowed.
- seg_sel is always exactly one-hot, never zero.
- Glyph table (active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - blank=1111111
- Leading-zero blanking (BLANK_LZ=1):
  - Digit k is blank when k > 0 and digits k..DIGITS-1 are all zero.
  - Blanking is evaluated from score at the scan-advance edge.
- clear, inc and dec do not affect the scan; it runs continuously.
- clr asserted mid-scan or mid-count returns everything to the reset values immediately. The first scan advance then occurs 2**SCAN_DIV cycles after clr deasserts.

Decomposition:
- Shared package bcd_disp_pkg holds:
  - the SEG_0..SEG_9 and SEG_BLANK 7-bit constants;
  - a function bcd_to_seg(4-bit) returning 7 bits.
- One natural sub-module, bcd_digit:
  - a 4-bit digit with carry_in, borrow_in, carry_out and borrow_out;
  - instantiated DIGITS times by a generate loop.
- Limit detection and saturation override live in the top of bcd_score_display, not in bcd_digit.

Test Plan:
1. DIGITS=4, SCAN_DIV=2: reset, then 3 inc strobes.
   - Required: score=0x0003.
   - Across the 4 scan slots segment shows 0000110, 1111111, 1111111, 1111111 with seg_sel=0001, 0010, 0100, 1000.
2. score preloaded by 9999 inc strobes, SATURATE=0, then one more inc.
   - Required: score=0x0000 and limit high for exactly 1 cycle.
   - Repeat with SATURATE=1: score stays 0x9999 and limit pulses.
3. Starting from score=0x0100, one dec strobe.
   - Required: score=0x0099; blanking shows digit 2 and digit 3 blank.
   - At 0, dec gives 0x9999 with SATURATE=0, or holds 0x0000 with SATURATE=1.
4. Simultaneous events at score=0x0042:
   - inc and dec in the same cycle: score unchanged, limit=0.
   - clear together with inc: score=0x0000.
5. BLANK_LZ=0, score=0x0007: all four slots lit, showing 0000001, 0000001, 0000001, 0001111.
6. clr pulsed asynchronously between clk edges while seg_sel=0100 and score=0x0123.
   - Required: score=0, seg_sel=0001 and segment=0000001 before the next clk edge.
   - Next scan advance occurs exactly 4 cycles after clr deasserts (SCAN_DIV=2).
